// File: rtl/sik_mem_server.sv
// Data-memory responder for the two-thread SIK core: round-robin arbitration
// between two load/store request channels over a single-ported word memory.
module sik_mem_server #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  input  logic              req2_valid,
  output logic              req2_ready,
  input  logic              req2_we,
  input  logic [ADDR_W-1:0] req2_addr,
  input  logic [DATA_W-1:0] req2_wdata,
  output logic              rsp2_valid,
  input  logic              rsp2_ready,
  output logic [DATA_W-1:0] rsp2_data,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              prio;      // 0 favours thread 1, 1 favours thread 2
  logic              cur;       // latched thread: 0 = thread 1, 1 = thread 2
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              grant1;
  logic              grant2;
  logic              rsp_sel_ready;
  logic [DATA_W-1:0] access_data;

  // Lone requester always wins; contention resolved by the pointer
  assign grant1        = req1_valid && (!req2_valid || !prio);
  assign grant2        = req2_valid && (!req1_valid || prio);
  assign req1_ready    = (state == IDLE) && grant1;
  assign req2_ready    = (state == IDLE) && grant2;
  assign rsp_sel_ready = cur ? rsp2_ready : rsp1_ready;
  assign access_data   = lat_we ? lat_wdata : mem[lat_addr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      prio       <= 1'b0;
      cur        <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rsp1_valid <= 1'b0;
      rsp2_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp2_data  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant1 || grant2) begin
            cur       <= grant2;
            lat_we    <= grant2 ? req2_we    : req1_we;
            lat_addr  <= grant2 ? req2_addr  : req1_addr;
            lat_wdata <= grant2 ? req2_wdata : req1_wdata;
            state     <= ACCESS;
            busy      <= 1'b1;
          end
        end
        ACCESS: begin
          state      <= RESP;
          rsp1_valid <= !cur;
          rsp2_valid <= cur;
          if (cur) rsp2_data <= access_data;
          else     rsp1_data <= access_data;
        end
        RESP: begin
          if (rsp_sel_ready) begin
            state      <= IDLE;
            busy       <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp2_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp2_data  <= '0;
            prio       <= ~cur;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store commits only in ACCESS and never on a reset edge
  always_ff @(posedge clk) begin
    if (reset && (state == ACCESS) && lat_we) mem[lat_addr] <= lat_wdata;
  end

endmodule
